shift_reg_universal: RTL and testbench

Parametrised universal shift register, the successor to the fixed single-bit serial-in/serial-out register. Supports hold, shift-right, shift-left and parallel-load modes over a WIDTH-bit register, with serial ports at both ends and full parallel access. A shift counter raises a one-cycle frame pulse after every WIDTH shifts. It sits at serializer/deserializer boundaries and delay-line positions in the datapath.

---
 rtl/shift_reg_universal_pkg.sv | 10 +
 rtl/shift_reg_universal_if.sv | 23 ++
 rtl/shift_reg_universal_frame_counter.sv | 24 ++
 rtl/shift_reg_universal.sv | 39 +++
 tb/tb_shift_reg_universal.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/shift_reg_universal_pkg.sv
// shift_pkg: mode encoding shared by the universal shift register and its bus
package shift_pkg;
  localparam int MODE_W = 2;
  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 2'd0,
    MODE_SHR  = 2'd1,
    MODE_SHL  = 2'd2,
    MODE_LOAD = 2'd3
  } mode_t;
endpackage

// File: rtl/shift_reg_universal_if.sv
// shift_reg_universal_if: control, serial and parallel signals of the universal shift register
interface shift_reg_universal_if #(parameter int WIDTH = 8);
  import shift_pkg::*;
  localparam int CNT_W = $clog2(WIDTH);
  logic en;
  mode_t mode;
  logic sin_msb;
  logic sin_lsb;
  logic [WIDTH-1:0] par_in;
  logic [WIDTH-1:0] par_out;
  logic sout_lsb;
  logic sout_msb;
  logic [CNT_W-1:0] shift_cnt;
  logic frame_done;
  modport master (
    output en, mode, sin_msb, sin_lsb, par_in,
    input par_out, sout_lsb, sout_msb, shift_cnt, frame_done
  );
  modport slave (
    input en, mode, sin_msb, sin_lsb, par_in,
    output par_out, sout_lsb, sout_msb, shift_cnt, frame_done
  );
endinterface

// File: rtl/shift_reg_universal_frame_counter.sv
// shift_frame_counter: modulo-WIDTH shift counter with sync clear and registered wrap pulse
module shift_frame_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);
  logic wrap;
  assign wrap = cnt == CNT_W'(WIDTH - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= inc && wrap;
      if (clr) cnt <= '0;
      else if (inc) cnt <= wrap ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/shift_reg_universal.sv
// shift_reg_universal: hold/shift-right/shift-left/load register with frame counter
module shift_reg_universal #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic reset,
  shift_reg_universal_if.slave bus
);
  import shift_pkg::*;
  localparam int CNT_W = $clog2(WIDTH);
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] nxt;
  logic [CNT_W-1:0] cnt;
  logic done;
  logic shift;
  logic load;
  always_comb
    nxt = bus.mode == MODE_SHR  ? {bus.sin_msb, q[WIDTH-1:1]} :
          bus.mode == MODE_SHL  ? {q[WIDTH-2:0], bus.sin_lsb} :
          bus.mode == MODE_LOAD ? bus.par_in : q;
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (bus.en) q <= nxt;
  assign shift = bus.en && (bus.mode == MODE_SHR || bus.mode == MODE_SHL);
  assign load  = bus.en && bus.mode == MODE_LOAD;
  shift_frame_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (load),
    .inc  (shift),
    .cnt  (cnt),
    .done (done)
  );
  assign bus.par_out    = q;
  assign bus.sout_lsb   = q[0];
  assign bus.sout_msb   = q[WIDTH-1];
  assign bus.shift_cnt  = cnt;
  assign bus.frame_done = done;
endmodule

// File: tb/tb_shift_reg_universal.sv
// tb_shift_reg_universal: vector table, corner sequences and random model check at WIDTH 4 and 8
module tb_shift_reg_universal;
  import shift_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  shift_reg_universal_if #(.WIDTH(4)) b4 ();
  shift_reg_universal_if #(.WIDTH(8)) b8 ();
  shift_reg_universal #(.WIDTH(4)) u4 (.clk(clk), .reset(reset), .bus(b4.slave));
  shift_reg_universal #(.WIDTH(8)) u8 (.clk(clk), .reset(reset), .bus(b8.slave));
  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic       smsb;
    logic       slsb;
    logic [3:0] par;
    logic [3:0] exp_q;
    logic [1:0] exp_cnt;
    logic       exp_fd;
  } vec_t;
  vec_t v[$];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive4(input logic e, input logic [1:0] m, input logic sm, input logic sl, input logic [3:0] p);
    b4.en = e;
    b4.mode = mode_t'(m);
    b4.sin_msb = sm;
    b4.sin_lsb = sl;
    b4.par_in = p;
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, " par4"}, 64'(b4.par_out), 0);
    chk({nm, " cnt4"}, 64'(b4.shift_cnt), 0);
    chk({nm, " fd4"}, 64'(b4.frame_done), 0);
    chk({nm, " slsb4"}, 64'(b4.sout_lsb), 0);
    chk({nm, " smsb4"}, 64'(b4.sout_msb), 0);
    chk({nm, " par8"}, 64'(b8.par_out), 0);
    chk({nm, " cnt8"}, 64'(b8.shift_cnt), 0);
  endtask
  logic [63:0] mq[2];
  int mn[2];
  logic mfd[2];
  int ww[2] = '{4, 8};
  logic re[2], rsm[2], rsl[2];
  logic [1:0] rm[2];
  logic [63:0] rp[2];
  logic bits[1:16];
  int pulses;
  initial begin
    drive4(0, 0, 0, 0, 0);
    b8.en = 0; b8.mode = MODE_HOLD; b8.sin_msb = 0; b8.sin_lsb = 0; b8.par_in = '0;
    #2 reset = 1'b1;
    #1 chk_zero("reset");
    @(negedge clk) reset = 1'b0;
    v.push_back('{1, 1, 1, 0, 4'h0, 4'b1000, 2'd1, 0});
    v.push_back('{1, 1, 1, 0, 4'h0, 4'b1100, 2'd2, 0});
    v.push_back('{1, 1, 0, 0, 4'h0, 4'b0110, 2'd3, 0});
    v.push_back('{1, 1, 1, 0, 4'h0, 4'b1011, 2'd0, 1});
    v.push_back('{1, 0, 1, 1, 4'h0, 4'b1011, 2'd0, 0});
    v.push_back('{1, 3, 0, 0, 4'b1010, 4'b1010, 2'd0, 0});
    v.push_back('{1, 2, 0, 1, 4'h0, 4'b0101, 2'd1, 0});
    v.push_back('{1, 2, 0, 1, 4'h0, 4'b1011, 2'd2, 0});
    v.push_back('{1, 1, 0, 0, 4'h0, 4'b0101, 2'd3, 0});
    v.push_back('{1, 3, 0, 0, 4'b0011, 4'b0011, 2'd0, 0});
    v.push_back('{1, 1, 0, 0, 4'h0, 4'b0001, 2'd1, 0});
    v.push_back('{1, 2, 0, 0, 4'h0, 4'b0010, 2'd2, 0});
    v.push_back('{1, 1, 0, 0, 4'h0, 4'b0001, 2'd3, 0});
    v.push_back('{1, 1, 0, 0, 4'h0, 4'b0000, 2'd0, 1});
    v.push_back('{0, 1, 1, 1, 4'hf, 4'b0000, 2'd0, 0});
    v.push_back('{0, 3, 1, 1, 4'hf, 4'b0000, 2'd0, 0});
    v.push_back('{1, 1, 1, 0, 4'h0, 4'b1000, 2'd1, 0});
    v.push_back('{0, 1, 1, 0, 4'h0, 4'b1000, 2'd1, 0});
    v.push_back('{1, 0, 1, 1, 4'h5, 4'b1000, 2'd1, 0});
    foreach (v[i]) begin
      drive4(v[i].en, v[i].mode, v[i].smsb, v[i].slsb, v[i].par);
      tick;
      chk($sformatf("vec%0d par", i), 64'(b4.par_out), 64'(v[i].exp_q));
      chk($sformatf("vec%0d cnt", i), 64'(b4.shift_cnt), 64'(v[i].exp_cnt));
      chk($sformatf("vec%0d fd", i), 64'(b4.frame_done), 64'(v[i].exp_fd));
      chk($sformatf("vec%0d slsb", i), 64'(b4.sout_lsb), 64'(v[i].exp_q[0]));
      chk($sformatf("vec%0d smsb", i), 64'(b4.sout_msb), 64'(v[i].exp_q[3]));
    end
    drive4(1, 3, 0, 0, 4'hf);
    tick;
    drive4(1, 1, 1, 0, 0);
    repeat (3) tick;
    chk("pre-async par", 64'(b4.par_out), 64'hf);
    chk("pre-async cnt", 64'(b4.shift_cnt), 3);
    #2 reset = 1'b1;
    #1 chk_zero("async");
    drive4(0, 0, 0, 0, 0);
    @(negedge clk) reset = 1'b0;
    pulses = 0;
    b8.en = 1;
    b8.mode = MODE_SHR;
    for (int k = 1; k <= 16; k++) begin
      bits[k] = 1'($urandom);
      b8.sin_msb = bits[k];
      tick;
      if (b8.frame_done) pulses++;
      if (k >= 8) chk($sformatf("siso edge%0d", k), 64'(b8.sout_lsb), 64'(bits[k-7]));
    end
    chk("siso pulses", 64'(pulses), 2);
    chk("siso cnt", 64'(b8.shift_cnt), 0);
    for (int k = 0; k < 2; k++) begin
      mq[k] = 64'(k == 0 ? b4.par_out : b8.par_out);
      mn[k] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        re[k] = ($urandom_range(0, 4) != 0);
        rm[k] = 2'($urandom);
        if (rm[k] == 2'd3 && $urandom_range(0, 2) != 0) rm[k] = 2'($urandom_range(1, 2));
        rsm[k] = 1'($urandom);
        rsl[k] = 1'($urandom);
        rp[k] = {$urandom, $urandom} & ((64'd1 << ww[k]) - 1);
        mfd[k] = 1'b0;
        if (re[k]) begin
          if (rm[k] == 2'd3) begin
            mq[k] = rp[k];
            mn[k] = 0;
          end else if (rm[k] != 2'd0) begin
            mq[k] = rm[k] == 2'd1 ? (mq[k] >> 1) | (64'(rsm[k]) << (ww[k] - 1))
                                  : ((mq[k] << 1) | 64'(rsl[k])) & ((64'd1 << ww[k]) - 1);
            mn[k]++;
            mfd[k] = (mn[k] % ww[k]) == 0;
          end
        end
      end
      drive4(re[0], rm[0], rsm[0], rsl[0], rp[0][3:0]);
      b8.en = re[1]; b8.mode = mode_t'(rm[1]); b8.sin_msb = rsm[1]; b8.sin_lsb = rsl[1]; b8.par_in = rp[1][7:0];
      tick;
      chk($sformatf("rnd%0d par4", c), 64'(b4.par_out), mq[0]);
      chk($sformatf("rnd%0d cnt4", c), 64'(b4.shift_cnt), 64'(mn[0] % 4));
      chk($sformatf("rnd%0d fd4", c), 64'(b4.frame_done), 64'(mfd[0]));
      chk($sformatf("rnd%0d par8", c), 64'(b8.par_out), mq[1]);
      chk($sformatf("rnd%0d cnt8", c), 64'(b8.shift_cnt), 64'(mn[1] % 8));
      chk($sformatf("rnd%0d fd8", c), 64'(b8.frame_done), 64'(mfd[1]));
      chk($sformatf("rnd%0d slsb8", c), 64'(b8.sout_lsb), 64'(mq[1][0]));
      chk($sformatf("rnd%0d smsb8", c), 64'(b8.sout_msb), 64'(mq[1][7]));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
